// File: rtl/reg_file_pkg.sv
// Shared widths, types and helpers for the architectural register file
// and its rename-tag table.
package reg_file_pkg;

  localparam int ROB_WIDTH = 5;
  localparam int NUM_REGS  = 32;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W     = 32;

  typedef logic [ROB_WIDTH-1:0] rob_id_t;
  typedef logic [REG_IDX_W-1:0] reg_id_t;
  typedef logic [XLEN-1:0]      xlen_t;

  // ROB id 0 means "no producer": the register value is ready.
  localparam rob_id_t ROB_ID_NONE = '0;

  function automatic logic is_zero_reg(input reg_id_t id);
    return (id == reg_id_t'(0));
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational source-operand port: index -> {value, producer tag}.
// A commit presented this cycle is forwarded so the reader never sees a stale value or tag.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  reg_id_t                          rs_id,
  input  logic [NUM_REGS-1:0][XLEN-1:0]    regs,
  input  logic [NUM_REGS-1:0][ROB_WIDTH-1:0] tags,
  input  logic                             commit_enabled,
  input  reg_id_t                          commit_reg_id,
  input  xlen_t                            commit_data,
  input  rob_id_t                          commit_rob_id,
  output xlen_t                            rs_value,
  output rob_id_t                          rs_tag
);

  always_comb begin
    rs_value = '0;
    rs_tag   = ROB_ID_NONE;
    if (!is_zero_reg(rs_id)) begin
      if (commit_enabled && (commit_reg_id == rs_id)) begin
        rs_value = commit_data;
      end else begin
        rs_value = regs[rs_id];
      end
      // Matching on the ROB id alone is enough: ids are unique while in flight.
      if (commit_enabled && (tags[rs_id] == commit_rob_id)) begin
        rs_tag = ROB_ID_NONE;
      end else begin
        rs_tag = tags[rs_id];
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file plus rename-tag table: takes ROB commits and flushes,
// records dispatch renames, and serves two combinational source-read ports.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush_in,
  input  logic                 commit_enabled,
  input  logic [REG_IDX_W-1:0] commit_reg_id,
  input  logic [XLEN-1:0]      commit_data,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic                 rename_enabled,
  input  logic [REG_IDX_W-1:0] rename_reg_id,
  input  logic [ROB_WIDTH-1:0] rename_rob_id,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  output logic [XLEN-1:0]      rs1_value,
  output logic [XLEN-1:0]      rs2_value,
  output logic [ROB_WIDTH-1:0] rs1_tag,
  output logic [ROB_WIDTH-1:0] rs2_tag,
  output logic [CNT_W-1:0]     commit_count
);

  logic [NUM_REGS-1:0][XLEN-1:0]      regs;
  logic [NUM_REGS-1:0][ROB_WIDTH-1:0] tags;

  // Later non-blocking writes take priority: flush beats rename beats the commit tag clear.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      regs         <= '0;
      tags         <= '0;
      commit_count <= '0;
    end else begin
      if (commit_enabled) begin
        commit_count <= commit_count + CNT_W'(1);
        if (!is_zero_reg(commit_reg_id)) begin
          regs[commit_reg_id] <= commit_data;
          if (tags[commit_reg_id] == commit_rob_id) begin
            tags[commit_reg_id] <= ROB_ID_NONE;
          end
        end
      end
      if (flush_in) begin
        tags <= '0;
      end else if (rename_enabled && !is_zero_reg(rename_reg_id)) begin
        tags[rename_reg_id] <= rename_rob_id;
      end
    end
  end

  reg_file_read_port u_rs1_port (
    .rs_id          (rs1_id),
    .regs           (regs),
    .tags           (tags),
    .commit_enabled (commit_enabled),
    .commit_reg_id  (commit_reg_id),
    .commit_data    (commit_data),
    .commit_rob_id  (commit_rob_id),
    .rs_value       (rs1_value),
    .rs_tag         (rs1_tag)
  );

  reg_file_read_port u_rs2_port (
    .rs_id          (rs2_id),
    .regs           (regs),
    .tags           (tags),
    .commit_enabled (commit_enabled),
    .commit_reg_id  (commit_reg_id),
    .commit_data    (commit_data),
    .commit_rob_id  (commit_rob_id),
    .rs_value       (rs2_value),
    .rs_tag         (rs2_tag)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected read-port/count values,
// a negedge monitor pops and compares them.
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        commit_enabled;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_data;
  logic [4:0]  commit_rob_id;
  logic        rename_enabled;
  logic [4:0]  rename_reg_id;
  logic [4:0]  rename_rob_id;
  logic [4:0]  rs1_id, rs2_id;
  logic [31:0] rs1_value, rs2_value;
  logic [4:0]  rs1_tag, rs2_tag;
  logic [31:0] commit_count;

  typedef struct packed {
    logic [31:0] v1;
    logic [4:0]  t1;
    logic [31:0] v2;
    logic [4:0]  t2;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  chk_req = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk_in = ~clk_in;

  reg_file dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .flush_in       (flush_in),
    .commit_enabled (commit_enabled),
    .commit_reg_id  (commit_reg_id),
    .commit_data    (commit_data),
    .commit_rob_id  (commit_rob_id),
    .rename_enabled (rename_enabled),
    .rename_reg_id  (rename_reg_id),
    .rename_rob_id  (rename_rob_id),
    .rs1_id         (rs1_id),
    .rs2_id         (rs2_id),
    .rs1_value      (rs1_value),
    .rs2_value      (rs2_value),
    .rs1_tag        (rs1_tag),
    .rs2_tag        (rs2_tag),
    .commit_count   (commit_count)
  );

  // Monitor: outputs are presented whenever the stimulus raises chk_req.
  always @(negedge clk_in) begin
    if (chk_req) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: output presented with no expected entry");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({rs1_value, rs1_tag, rs2_value, rs2_tag, commit_count} != e) begin
          n_fail++;
          $display("FAIL %s: got v1=%h t1=%0d v2=%h t2=%0d cnt=%0d, expected v1=%h t1=%0d v2=%h t2=%0d cnt=%0d",
                   nm, rs1_value, rs1_tag, rs2_value, rs2_tag, commit_count,
                   e.v1, e.t1, e.v2, e.t2, e.cnt);
        end
      end
    end
  end

  // Advance one cycle and return all strobes to idle; read ids are kept.
  task automatic next_cycle();
    @(posedge clk_in);
    #1;
    chk_req        = 1'b0;
    flush_in       = 1'b0;
    commit_enabled = 1'b0;
    rename_enabled = 1'b0;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] data, input logic [4:0] rob);
    commit_enabled = 1'b1;
    commit_reg_id  = rd;
    commit_data    = data;
    commit_rob_id  = rob;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] rob);
    rename_enabled = 1'b1;
    rename_reg_id  = rd;
    rename_rob_id  = rob;
  endtask

  task automatic expect_rd(input string nm, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] v1, input logic [4:0] t1,
                           input logic [31:0] v2, input logic [4:0] t2,
                           input logic [31:0] cnt);
    rs1_id = r1;
    rs2_id = r2;
    exp_q.push_back('{v1: v1, t1: t1, v2: v2, t2: t2, cnt: cnt});
    name_q.push_back(nm);
    chk_req = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0; flush_in = 1'b0; commit_enabled = 1'b0; rename_enabled = 1'b0;
    commit_reg_id = '0; commit_data = '0; commit_rob_id = '0;
    rename_reg_id = '0; rename_rob_id = '0; rs1_id = '0; rs2_id = '0;

    next_cycle();
    expect_rd("reset_state", 5, 3, 32'h0, 0, 32'h0, 0, 0);
    next_cycle();
    rst_in = 1'b1;

    // Rename not visible in the same cycle; visible the next.
    next_cycle(); rename(5, 7);
    expect_rd("rename_not_bypassed", 5, 0, 32'h0, 0, 32'h0, 0, 0);
    next_cycle();
    expect_rd("rename_visible", 5, 0, 32'h0, 7, 32'h0, 0, 0);
    next_cycle(); commit(5, 32'hDEAD_BEEF, 7);
    expect_rd("commit_bypass", 5, 5, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0);
    next_cycle();
    expect_rd("commit_stored", 5, 0, 32'hDEAD_BEEF, 0, 32'h0, 0, 1);

    // Stale commit writes data but keeps the newer tag.
    next_cycle(); rename(5, 7);
    next_cycle(); rename(5, 9);
    expect_rd("second_rename_pending", 5, 0, 32'hDEAD_BEEF, 7, 32'h0, 0, 1);
    next_cycle(); commit(5, 32'h11, 7);
    expect_rd("stale_commit_bypass", 5, 0, 32'h11, 9, 32'h0, 0, 1);
    next_cycle();
    expect_rd("stale_commit_stored", 5, 0, 32'h11, 9, 32'h0, 0, 2);

    // Same-cycle commit and rename of x3: rename tag wins, old producer bypassed.
    next_cycle(); rename(3, 4);
    next_cycle(); commit(3, 32'hA5A5_0003, 4); rename(3, 6);
    expect_rd("same_cycle_commit_rename", 3, 0, 32'hA5A5_0003, 0, 32'h0, 0, 2);
    next_cycle();
    expect_rd("rename_wins_over_clear", 3, 0, 32'hA5A5_0003, 6, 32'h0, 0, 3);

    // Flush clears every tag and drops the concurrent rename.
    next_cycle(); rename(1, 2);
    next_cycle(); rename(2, 3);
    expect_rd("x1_tag_before_flush", 1, 2, 32'h0, 2, 32'h0, 0, 3);
    next_cycle(); flush_in = 1'b1; rename(4, 5);
    expect_rd("flush_not_bypassed", 1, 2, 32'h0, 2, 32'h0, 3, 3);
    next_cycle();
    expect_rd("flush_cleared_x1_x2", 1, 2, 32'h0, 0, 32'h0, 0, 3);
    next_cycle();
    expect_rd("flush_dropped_rename", 4, 5, 32'h0, 0, 32'h11, 0, 3);
    next_cycle();
    expect_rd("flush_cleared_x3", 3, 0, 32'hA5A5_0003, 0, 32'h0, 0, 3);

    // Commit in a flush cycle still writes and counts.
    next_cycle(); flush_in = 1'b1; commit(6, 32'h66, 1);
    expect_rd("flush_commit_bypass", 6, 0, 32'h66, 0, 32'h0, 0, 3);
    next_cycle();
    expect_rd("flush_commit_stored", 6, 0, 32'h66, 0, 32'h0, 0, 4);

    // x0 ignores rename and commit data, but the commit is counted.
    next_cycle(); rename(0, 3); commit(0, 32'h55, 3);
    expect_rd("x0_same_cycle", 0, 0, 32'h0, 0, 32'h0, 0, 4);
    next_cycle();
    expect_rd("x0_after", 0, 6, 32'h0, 0, 32'h66, 0, 5);

    // Renaming to ROB id 0 marks the register ready.
    next_cycle(); rename(7, 8);
    next_cycle(); rename(7, 0);
    expect_rd("rob8_pending", 7, 0, 32'h0, 8, 32'h0, 0, 5);
    next_cycle();
    expect_rd("rob0_ready", 7, 0, 32'h0, 0, 32'h0, 0, 5);

    // Asynchronous reset mid-run clears everything immediately.
    next_cycle(); rename(5, 12);
    next_cycle(); rst_in = 1'b0;
    expect_rd("async_reset_mid_run", 5, 6, 32'h0, 0, 32'h0, 0, 0);
    next_cycle(); rst_in = 1'b1;
    next_cycle();
    expect_rd("after_reset_release", 5, 3, 32'h0, 0, 32'h0, 0, 0);
    next_cycle();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
